// File: rtl/display_scanner_if.sv
// Groups the scanner's control inputs and display outputs into one bundle.
//   master : value/counter logic side. It drives enable, digits_in and digit_en.
//   slave  : the scanner. It drives AN, digit_sel, digit_val and slot_tick.
interface display_scanner_if #(
    parameter int unsigned N_DIGITS = 4
);
    localparam int unsigned SEL_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                    enable;
    logic [4*N_DIGITS-1:0]   digits_in;
    logic [N_DIGITS-1:0]     digit_en;
    logic [N_DIGITS-1:0]     AN;
    logic [SEL_W-1:0]        digit_sel;
    logic [3:0]              digit_val;
    logic                    slot_tick;

    modport master (
        output enable, digits_in, digit_en,
        input  AN, digit_sel, digit_val, slot_tick
    );

    modport slave (
        input  enable, digits_in, digit_en,
        output AN, digit_sel, digit_val, slot_tick
    );
endinterface

// File: rtl/display_scanner.sv
// Time-multiplexed scanner for N common-anode seven-segment digits.
// Each digit owns a slot of PRESCALE cycles. The first BLANK_CYCLES of a slot keep
// every anode off, so the previous digit does not ghost. The digit nibble and its
// enable bit are captured at the start of the slot and held for the whole slot.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : display_scanner_if.slave
//              inputs  : enable, digits_in, digit_en
//              outputs : AN, digit_sel, digit_val, slot_tick (all registered)
// Optional build macro: LEADING_ZERO_BLANK_EN. When it is defined, digits above
// the highest nonzero nibble are also masked. Digit 0 is always shown.
module display_scanner #(
    parameter int unsigned N_DIGITS      = 4,
    parameter int unsigned PRESCALE      = 100000,
    parameter int unsigned BLANK_CYCLES  = 1000,
    parameter bit          AN_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    display_scanner_if.slave  bus
);
    localparam int unsigned SEL_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned CNT_W    = $clog2(PRESCALE);
    localparam bit          NO_BLANK = (BLANK_CYCLES == 0);
    localparam logic [N_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : '0;

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t             state_q,   state_n;
    logic [CNT_W-1:0]   cnt_q,     cnt_n;
    logic [SEL_W-1:0]   sel_q,     sel_n;
    logic [3:0]         val_q,     val_n;
    logic               en_snap_q, en_snap_n;
    logic               tick_q,    tick_n;
    logic [N_DIGITS-1:0] an_q,     an_n;

    logic [SEL_W-1:0]   load_idx;
    logic               lz_ok;
    logic [N_DIGITS-1:0] onehot;

    // Index to snapshot at the next slot start. The first slot after reset is always digit 0.
    always_comb begin
        load_idx = '0;
        if (state_q == ST_SCAN && sel_q != SEL_W'(N_DIGITS - 1)) begin
            load_idx = sel_q + SEL_W'(1);
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [SEL_W-1:0] hi_nz;

    // Highest nonzero nibble. It is 0 when every nibble is zero, so digit 0 stays lit.
    always_comb begin
        hi_nz = '0;
        for (int k = 0; k < int'(N_DIGITS); k++) begin
            if (bus.digits_in[4*k +: 4] != 4'h0) begin
                hi_nz = SEL_W'(k);
            end
        end
    end

    assign lz_ok = (load_idx <= hi_nz);
`else
    assign lz_ok = 1'b1;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        sel_n     = sel_q;
        val_n     = val_q;
        en_snap_n = en_snap_q;
        tick_n    = 1'b0;
        an_n      = AN_OFF;
        onehot    = '0;

        if (bus.enable) begin
            if (state_q == ST_IDLE || cnt_q == CNT_W'(PRESCALE - 1)) begin
                // Slot start: advance the index and snapshot the digit and its mask.
                state_n   = ST_SCAN;
                cnt_n     = '0;
                sel_n     = load_idx;
                val_n     = bus.digits_in[{load_idx, 2'b00} +: 4];
                en_snap_n = bus.digit_en[load_idx] & lz_ok;
                tick_n    = 1'b1;
            end else begin
                cnt_n = cnt_q + CNT_W'(1);
            end

            // AN is computed from next-cycle state, so it stays aligned with cnt.
            if (en_snap_n && (NO_BLANK || cnt_n >= CNT_W'(BLANK_CYCLES))) begin
                onehot = N_DIGITS'(1) << sel_n;
                an_n   = AN_ACTIVE_LOW ? ~onehot : onehot;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            val_q     <= '0;
            en_snap_q <= 1'b0;
            tick_q    <= 1'b0;
            an_q      <= AN_OFF;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            sel_q     <= sel_n;
            val_q     <= val_n;
            en_snap_q <= en_snap_n;
            tick_q    <= tick_n;
            an_q      <= an_n;
        end
    end

    assign bus.AN        = an_q;
    assign bus.digit_sel = sel_q;
    assign bus.digit_val = val_q;
    assign bus.slot_tick = tick_q;
endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner: 4 digits, 8-cycle slots, 2 blank cycles.
module tb_display_scanner;
    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    display_scanner_if #(.N_DIGITS(4)) bus ();

    display_scanner #(
        .N_DIGITS     (4),
        .PRESCALE     (8),
        .BLANK_CYCLES (2),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks one sampled cycle. When lit, AN is on only from cnt >= 2 onward.
    task automatic expect_cycle(input string tag, input int s, input logic [3:0] v,
                                input bit lit, input int c);
        logic [3:0] an_exp;
        an_exp = 4'hF;
        if (lit && c >= 2) an_exp[s] = 1'b0;
        check($sformatf("%s_s%0d_c%0d_an", tag, s, c), 32'(bus.AN), 32'(an_exp));
        check($sformatf("%s_s%0d_c%0d_sel", tag, s, c), 32'(bus.digit_sel), 32'(s));
        check($sformatf("%s_s%0d_c%0d_val", tag, s, c), 32'(bus.digit_val), 32'(v));
        check($sformatf("%s_s%0d_c%0d_tick", tag, s, c), 32'(bus.slot_tick), 32'(c == 0));
    endtask

    task automatic run_slot(input string tag, input int s, input logic [3:0] v, input bit lit);
        for (int c = 0; c < 8; c++) begin
            expect_cycle(tag, s, v, lit, c);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] d;
        reset_n       = 1'b0;
        bus.enable    = 1'b1;
        bus.digits_in = 16'h1234;
        bus.digit_en  = 4'hF;
        repeat (2) @(negedge clk);

        check("rst_an",   32'(bus.AN),        32'hF);
        check("rst_sel",  32'(bus.digit_sel), 32'h0);
        check("rst_val",  32'(bus.digit_val), 32'h0);
        check("rst_tick", 32'(bus.slot_tick), 32'h0);
        check("rst_cnt",  32'(dut.cnt_q),     32'h0);

        // Basic scan across all four slots, then the wrap back to slot 0.
        reset_n = 1'b1;
        @(negedge clk);
        d = 16'h1234;
        for (int s = 0; s < 4; s++) run_slot("t1", s, d[4*s +: 4], 1'b1);
        run_slot("t1w", 0, 4'h4, 1'b1);

        // A change to digits_in mid-slot takes effect only at the next slot.
        for (int c = 0; c < 4; c++) begin
            expect_cycle("t2", 1, 4'h3, 1'b1, c);
            @(negedge clk);
        end
        bus.digits_in = 16'hABCD;
        for (int c = 4; c < 8; c++) begin
            expect_cycle("t2", 1, 4'h3, 1'b1, c);
            @(negedge clk);
        end
        run_slot("t2", 2, 4'hB, 1'b1);
        bus.digit_en = 4'b1011;
        run_slot("t2", 3, 4'hA, 1'b1);

        // A masked digit keeps its slot but stays dark.
        run_slot("t3", 0, 4'hD, 1'b1);
        run_slot("t3", 1, 4'hC, 1'b1);
        run_slot("t3", 2, 4'hB, 1'b0);
        bus.digit_en = 4'hF;
        run_slot("t3", 3, 4'hA, 1'b1);

        // Enable drops at cnt=5, then resumes.
        run_slot("t4", 0, 4'hD, 1'b1);
        for (int c = 0; c < 5; c++) begin
            expect_cycle("t4", 1, 4'hC, 1'b1, c);
            @(negedge clk);
        end
        expect_cycle("t4", 1, 4'hC, 1'b1, 5);
        bus.enable = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t4_hold%0d_an", i),   32'(bus.AN),        32'hF);
            check($sformatf("t4_hold%0d_sel", i),  32'(bus.digit_sel), 32'h1);
            check($sformatf("t4_hold%0d_cnt", i),  32'(dut.cnt_q),     32'h5);
            check($sformatf("t4_hold%0d_tick", i), 32'(bus.slot_tick), 32'h0);
            @(negedge clk);
        end
        bus.enable = 1'b1;
        @(negedge clk);
        expect_cycle("t4r", 1, 4'hC, 1'b1, 6);
        @(negedge clk);
        expect_cycle("t4r", 1, 4'hC, 1'b1, 7);
        @(negedge clk);

        // Enable falls on the wrap cycle, so the slot does not advance.
        for (int c = 0; c < 7; c++) begin
            expect_cycle("t4w", 2, 4'hB, 1'b1, c);
            @(negedge clk);
        end
        expect_cycle("t4w", 2, 4'hB, 1'b1, 7);
        bus.enable = 1'b0;
        @(negedge clk);
        check("t4w_hold_sel",  32'(bus.digit_sel), 32'h2);
        check("t4w_hold_tick", 32'(bus.slot_tick), 32'h0);
        check("t4w_hold_an",   32'(bus.AN),        32'hF);
        check("t4w_hold_cnt",  32'(dut.cnt_q),     32'h7);
        bus.enable = 1'b1;
        @(negedge clk);
        run_slot("t4w", 3, 4'hA, 1'b1);

        // Asynchronous reset mid-slot, while digit 3 is lit.
        run_slot("t5", 0, 4'hD, 1'b1);
        run_slot("t5", 1, 4'hC, 1'b1);
        run_slot("t5", 2, 4'hB, 1'b1);
        for (int c = 0; c < 2; c++) begin
            expect_cycle("t5", 3, 4'hA, 1'b1, c);
            @(negedge clk);
        end
        expect_cycle("t5", 3, 4'hA, 1'b1, 2);
        bus.digits_in = 16'h0040;
        #2 reset_n = 1'b0;
        #1;
        check("t5_async_an",   32'(bus.AN),        32'hF);
        check("t5_async_sel",  32'(bus.digit_sel), 32'h0);
        check("t5_async_tick", 32'(bus.slot_tick), 32'h0);
        check("t5_async_val",  32'(bus.digit_val), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

`ifdef LEADING_ZERO_BLANK_EN
        run_slot("t6", 0, 4'h0, 1'b1);
        run_slot("t6", 1, 4'h4, 1'b1);
        run_slot("t6", 2, 4'h0, 1'b0);
        bus.digits_in = 16'h0000;
        run_slot("t6", 3, 4'h0, 1'b0);
        run_slot("t6z", 0, 4'h0, 1'b1);
        run_slot("t6z", 1, 4'h0, 1'b0);
        run_slot("t6z", 2, 4'h0, 1'b0);
        run_slot("t6z", 3, 4'h0, 1'b0);
`else
        run_slot("t6", 0, 4'h0, 1'b1);
        run_slot("t6", 1, 4'h4, 1'b1);
        run_slot("t6", 2, 4'h0, 1'b1);
        bus.digits_in = 16'h0000;
        run_slot("t6", 3, 4'h0, 1'b1);
        run_slot("t6z", 0, 4'h0, 1'b1);
        run_slot("t6z", 1, 4'h0, 1'b1);
        run_slot("t6z", 2, 4'h0, 1'b1);
        run_slot("t6z", 3, 4'h0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
Parametrised, time-multiplexed scanner for N common-anode seven-segment digits. It generalises the fixed 2-bit-counter anode decoder into a self-timed block with:
- internal refresh prescaler
- digit index counter
- per-slot anti-ghosting blank interval
- per-digit enable mask
- digit value snapshot
It sits between the value/counter logic and the shared BCD/hex-to-seven-segment decoder, driving the anode pins and selecting which nibble is decoded.

Parameters:
N_DIGITS, 4, number of digits scanned; legal range 1..16.
PRESCALE, 100000, clock cycles per digit slot; must be at least 2.
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be less than PRESCALE.
AN_ACTIVE_LOW, 1, 1 = anode on is 0 (board default); 0 = anode on is 1.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  1 = scanning runs; 0 = counters frozen and all anodes off
digits_in  input  4*N_DIGITS  packed nibbles; digit k is bits [4k+3:4k]; digit 0 is least significant
digit_en  input  N_DIGITS  per-digit display mask; 1 = digit lit in its slot
AN  output  N_DIGITS  anode drive; one-hot active level or all inactive
digit_sel  output  max(1,$clog2(N_DIGITS))  index of current slot
digit_val  output  4  nibble snapshot for current slot; feeds the segment decoder
slot_tick  output  1  one-cycle pulse on the first cycle of every slot

Behaviour:
- Clock and reset: single clock domain, all state flopped; reset is asynchronous assert and synchronous deassert externally.
- Reset values:
  - cnt = 0, digit_sel = 0, digit_val = 0, en_snap = 0, slot_tick = 0.
  - AN = all inactive: all ones when AN_ACTIVE_LOW = 1, else all zeros.
  - AN goes inactive immediately on reset_n falling, with no clock needed.
- Prescaler cnt:
  - Counts 0..PRESCALE-1 while enable = 1, then wraps to 0.
  - Held while enable = 0.
- Slot advance: on the edge where cnt wraps to 0, in the same edge:
  - digit_sel increments, wrapping from N_DIGITS-1 to 0.
  - digit_val <= digits_in[next index] and en_snap <= digit_en[next index].
  - slot_tick = 1 for exactly that cycle (cnt == 0).
- First slot after reset release: slot 0 starts on the first enabled cycle. Snapshot is taken for index 0, and slot_tick pulses on that cycle.
- Inputs outside the snapshot: changes on digits_in or digit_en mid-slot have no effect until the next slot.
- Anode drive:
  - AN is registered, with no combinational path from any input to AN.
  - AN shows the active level on bit digit_sel only when enable = 1, en_snap = 1 and cnt >= BLANK_CYCLES.
  - Otherwise all bits are inactive.
  - BLANK_CYCLES = 0 is legal and means no blank interval.
- Masked digits: a masked digit keeps its time slot, so the duty cycle of the other digits is unchanged.
- enable falling mid-slot:
  - AN goes inactive from the next cycle.
  - cnt and digit_sel hold.
  - On re-enable, counting resumes from the held cnt.
- N_DIGITS = 1: digit_sel is constant 0, and the snapshot refreshes every PRESCALE cycles.
- Simultaneous wrap and enable fall: enable is sampled first, so no advance occurs.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined:
  - At each slot start, also compute and register the index of the highest nonzero nibble of digits_in.
  - Any digit above that index is treated as masked for its slot.
  - Digit 0 is always shown, so all-zero input displays a single "0".
- Undefined: only digit_en masks digits.

Test Plan:
1. N_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, digits_in=16'h1234, digit_en=4'hF, enable=1, release reset:
   - Slot 0: AN=1111 for 2 cycles, then 1110 for 6 cycles with digit_val=4.
   - Following slots: AN=1101/val 3, 1011/val 2, 0111/val 1.
   - Wraps back to slot 0 after 32 cycles; slot_tick pulses every 8 cycles.
2. Change digits_in to 16'hABCD at cnt=4 of slot 1:
   - digit_val stays 3 through slot 1.
   - Slot 2 shows B, slot 3 shows A.
3. digit_en=4'b1011:
   - Slot 2 keeps AN=1111 for all 8 cycles.
   - Slot 3 starts exactly 8 cycles after slot 2 starts, with AN=0111.
4. Drop enable at cnt=5 of slot 1:
   - AN=1111 next cycle; cnt and digit_sel frozen for 10 cycles.
   - Re-enable: cnt resumes at 5, AN=1101 again, slot ends 3 cycles later.
5. Assert reset_n=0 mid-slot between clock edges:
   - AN=1111, digit_sel=0 and slot_tick=0 immediately.
   - After release, slot 0 restarts with the full blank interval.
6. With LEADING_ZERO_BLANK_EN:
   - digits_in=16'h0040: digits 3 and 2 stay dark; digits 1 and 0 lit.
   - digits_in=16'h0000: only digit 0 lit with value 0.
